// File: rtl/clock_divider_bank_pkg.sv
// clock_divider_bank_pkg: shared mode encodings and default divider constants
package clock_divider_bank_pkg;
  typedef enum logic {MODE_SQUARE = 1'b0, MODE_PULSE = 1'b1} mode_e;
  localparam int CNT_W_DEF = 26;
  localparam logic [CNT_W_DEF-1:0] DEFAULT_DIV_DEF = 26'd25000000;
endpackage

// File: rtl/clock_divider_bank_if.sv
// clock_divider_bank_if: control strobes and divided outputs of the divider bank
interface clock_divider_bank_if #(
  parameter int N_CH = 4,
  parameter int CNT_W = 26,
  parameter int CH_W = 2
);
  logic [N_CH-1:0] enable;
  logic [N_CH-1:0] mode;
  logic load;
  logic [CH_W-1:0] load_ch;
  logic [CNT_W-1:0] load_value;
  logic sync_clear;
  logic [N_CH-1:0] clk_out;
  logic [N_CH-1:0] tick;
  modport master (output enable, mode, load, load_ch, load_value, sync_clear, input clk_out, tick);
  modport slave (input enable, mode, load, load_ch, load_value, sync_clear, output clk_out, tick);
endinterface

// File: rtl/divider_channel.sv
// divider_channel: one divider lane with divisor, counter, terminal tick and square/pulse output
module divider_channel
  import clock_divider_bank_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_DEF)
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic mode,
  input  logic load,
  input  logic [CNT_W-1:0] load_value,
  input  logic sync_clear,
  output logic tick,
  output logic clk_out
);
  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic tick_q, tick_d, clk_out_q, clk_out_d, mode_q, mode_d, term;
  always_comb begin
    term = enable && cnt_q == div_q;
    cnt_d = (sync_clear || load || term) ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
    div_d = load ? load_value : div_q;
    tick_d = term && !load && !sync_clear;
    mode_d = mode;
    // a square wave resumed after pulse mode restarts its phase from low
    clk_out_d = sync_clear ? 1'b0 : mode == MODE_PULSE ? tick_d
              : (mode_q == MODE_PULSE ? 1'b0 : clk_out_q) ^ tick_d;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      div_q <= DEFAULT_DIV;
      tick_q <= 1'b0;
      clk_out_q <= 1'b0;
      mode_q <= MODE_SQUARE;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      tick_q <= tick_d;
      clk_out_q <= clk_out_d;
      mode_q <= mode_d;
    end
  end
  assign tick = tick_q;
  assign clk_out = clk_out_q;
endmodule

// File: rtl/clock_divider_bank.sv
// clock_divider_bank: bank of independent clock dividers with per-channel divisor load and global phase clear
module clock_divider_bank
  import clock_divider_bank_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_DEF),
  parameter int CH_W = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input logic clock,
  input logic reset,
  clock_divider_bank_if.slave bus
);
  logic [N_CH-1:0] load_hit, tick_w, clk_out_w;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign load_hit[i] = bus.load && bus.load_ch == CH_W'(i);
    divider_channel #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clock(clock),
      .reset(reset),
      .enable(bus.enable[i]),
      .mode(bus.mode[i]),
      .load(load_hit[i]),
      .load_value(bus.load_value),
      .sync_clear(bus.sync_clear),
      .tick(tick_w[i]),
      .clk_out(clk_out_w[i])
    );
  end
  assign bus.tick = tick_w;
  assign bus.clk_out = clk_out_w;
endmodule

// File: tb/tb_clock_divider_bank.sv
// tb_clock_divider_bank: directed vector bench for the 4-channel, 8-bit, divisor-3 divider bank
module tb_clock_divider_bank;
  localparam int N = 4, W = 8, CW = 3;
  logic clock = 1'b0, reset = 1'b1;
  int total = 0, bad = 0;
  clock_divider_bank_if #(.N_CH(N), .CNT_W(W), .CH_W(CW)) bus ();
  clock_divider_bank #(.N_CH(N), .CNT_W(W), .DEFAULT_DIV(8'd3), .CH_W(CW)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  always #5 clock = ~clock;
  typedef struct packed {
    logic [3:0] en, md;
    logic ld;
    logic [2:0] lch;
    logic [7:0] lval;
    logic clr;
    logic [3:0] et, ec;
  } vec_t;
  vec_t tbl[14];
  logic [3:0] t40[10] = '{4'h0, 4'h0, 4'h0, 4'h6, 4'h0, 4'h1, 4'h0, 4'h6, 4'h0, 4'h8};
  logic [3:0] c40[10] = '{4'h0, 4'h0, 4'h0, 4'h6, 4'h6, 4'h7, 4'h7, 4'h1, 4'h1, 4'h9};
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  task automatic check_both(input string name, input logic [3:0] mask, input logic [3:0] et, input logic [3:0] ec);
    chk({name, " tick"}, bus.tick & mask, et & mask);
    chk({name, " clk_out"}, bus.clk_out & mask, ec & mask);
  endtask
  task automatic drive(input logic [3:0] en, input logic [3:0] md, input logic ld, input logic [2:0] lch, input logic [7:0] lval, input logic clr);
    bus.enable = en;
    bus.mode = md;
    bus.load = ld;
    bus.load_ch = lch;
    bus.load_value = lval;
    bus.sync_clear = clr;
  endtask
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask
  task automatic run40(input string tag);
    drive(4'hF, 4'h0, 1'b0, 3'd0, 8'd0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step();
      check_both($sformatf("%s e%0d", tag, k + 1), 4'hF, t40[k], c40[k]);
    end
  endtask
  initial begin
    tbl = '{
      '{4'hF, 4'h0, 1'b0, 3'd0, 8'd0, 1'b0, 4'h0, 4'h0},
      '{4'hF, 4'h0, 1'b0, 3'd0, 8'd0, 1'b0, 4'h0, 4'h0},
      '{4'hF, 4'h0, 1'b0, 3'd0, 8'd0, 1'b0, 4'h0, 4'h0},
      '{4'hF, 4'h0, 1'b0, 3'd0, 8'd0, 1'b0, 4'hF, 4'hF},
      '{4'hF, 4'h0, 1'b0, 3'd0, 8'd0, 1'b0, 4'h0, 4'hF},
      '{4'hF, 4'h0, 1'b0, 3'd0, 8'd0, 1'b0, 4'h0, 4'hF},
      '{4'hF, 4'h0, 1'b0, 3'd0, 8'd0, 1'b0, 4'h0, 4'hF},
      '{4'hF, 4'h0, 1'b0, 3'd0, 8'd0, 1'b0, 4'hF, 4'h0},
      '{4'hF, 4'h4, 1'b1, 3'd2, 8'd0, 1'b0, 4'h0, 4'h0},
      '{4'hF, 4'h4, 1'b0, 3'd0, 8'd0, 1'b0, 4'h4, 4'h4},
      '{4'hF, 4'h4, 1'b0, 3'd0, 8'd0, 1'b0, 4'h4, 4'h4},
      '{4'hF, 4'h4, 1'b0, 3'd0, 8'd0, 1'b0, 4'hF, 4'hF},
      '{4'hF, 4'h4, 1'b0, 3'd0, 8'd0, 1'b0, 4'h4, 4'hF},
      '{4'hF, 4'h0, 1'b1, 3'd2, 8'd3, 1'b1, 4'h0, 4'h0}
    };
    drive(4'h0, 4'h0, 1'b0, 3'd0, 8'd0, 1'b0);
    #12;
    check_both("reset state", 4'hF, 4'h0, 4'h0);
    @(negedge clock);
    reset = 1'b0;
    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].md, tbl[i].ld, tbl[i].lch, tbl[i].lval, tbl[i].clr);
      step();
      check_both($sformatf("vec%0d", i), 4'hF, tbl[i].et, tbl[i].ec);
    end
    // enable hold on ch1 with clk_out high and cnt at 2
    drive(4'hF, 4'h0, 1'b0, 3'd0, 8'd0, 1'b0);
    repeat (6) step();
    drive(4'hD, 4'h0, 1'b0, 3'd0, 8'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      check_both($sformatf("hold%0d", k), 4'h2, 4'h0, 4'h2);
    end
    drive(4'hF, 4'h0, 1'b0, 3'd0, 8'd0, 1'b0);
    step();
    check_both("resume e1", 4'h2, 4'h0, 4'h2);
    step();
    check_both("resume e2", 4'h2, 4'h2, 4'h0);
    // sync_clear mid-period with ch0 divisor 5
    drive(4'hF, 4'h0, 1'b1, 3'd0, 8'd5, 1'b0);
    step();
    drive(4'hF, 4'h0, 1'b0, 3'd0, 8'd0, 1'b0);
    repeat (2) step();
    drive(4'hF, 4'h0, 1'b0, 3'd0, 8'd0, 1'b1);
    step();
    check_both("clear", 4'hF, 4'h0, 4'h0);
    drive(4'hF, 4'h0, 1'b0, 3'd0, 8'd0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step();
      check_both($sformatf("post clear e%0d", k), 4'hF,
                 k == 4 ? 4'hE : k == 6 ? 4'h1 : 4'h0,
                 k < 4 ? 4'h0 : k < 6 ? 4'hE : 4'hF);
    end
    drive(4'hF, 4'h0, 1'b1, 3'd3, 8'd9, 1'b1);
    step();
    check_both("load+clear", 4'hF, 4'h0, 4'h0);
    run40("div9");
    drive(4'hF, 4'h0, 1'b1, 3'd7, 8'd0, 1'b1);
    step();
    check_both("bad ch+clear", 4'hF, 4'h0, 4'h0);
    run40("ignored");
    // asynchronous reset between edges, with strobes present while held
    #2 reset = 1'b1;
    #1 check_both("async reset", 4'hF, 4'h0, 4'h0);
    drive(4'hF, 4'h0, 1'b1, 3'd0, 8'd1, 1'b1);
    step();
    check_both("in reset", 4'hF, 4'h0, 4'h0);
    reset = 1'b0;
    drive(4'hF, 4'h0, 1'b0, 3'd0, 8'd0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check_both($sformatf("after reset e%0d", k), 4'hF, k == 4 ? 4'hF : 4'h0, k == 4 ? 4'hF : 4'h0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
